// File: rtl/asl_filter_pkg.sv
// Shared types for the ASL prediction filter: FSM states, class/ASCII types
// and the class-index to letter mapping (J and Z are motion signs, so absent).
package asl_filter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int NUM_CLASSES_DEF = 24;

  typedef logic [4:0] class_idx_t;
  typedef logic [7:0] ascii_t;

  function automatic ascii_t idx_to_ascii(input class_idx_t idx);
    ascii_t r_ch;
    if (idx >= 5'(NUM_CLASSES_DEF)) begin
      r_ch = 8'h3F;
    end else if (idx <= 5'd8) begin
      r_ch = 8'h41 + {3'b000, idx};
    end else begin
      // indices past 'I' skip over 'J'
      r_ch = 8'h42 + {3'b000, idx};
    end
    return r_ch;
  endfunction

endpackage

// File: rtl/asl_letter_lut.sv
// Combinational class-index to ASCII letter lookup used on the commit path.
module asl_letter_lut
  import asl_filter_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [7:0] o_ascii
);

  assign o_ascii = idx_to_ascii(i_idx);

endmodule

// File: rtl/asl_prediction_filter.sv
// Debounces argmax winners into committed ASCII letters on a ready/valid port.
// Optional stale-candidate timeout enabled by defining ASL_FILTER_TIMEOUT_EN.
module asl_prediction_filter
  import asl_filter_pkg::*;
#(
  parameter int          NUM_CLASSES    = NUM_CLASSES_DEF,
  parameter int          STABLE_COUNT   = 4,
  parameter logic [7:0]  SCORE_THRESH   = 8'd64
`ifdef ASL_FILTER_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 50_000_000
`endif
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic [4:0]  idx_in,
  input  logic        valid_i,
  output logic [7:0]  letter_ascii,
  output logic [4:0]  letter_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow_o,
  output logic        illegal_o,
  output logic [15:0] commit_count
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_COUNT);
  localparam logic [5:0] NUM_N    = 6'(NUM_CLASSES);

  state_t      r_state, w_state_next;
  logic [4:0]  r_cand, w_cand_next;
  logic [3:0]  r_count, w_count_next;
  logic        w_legal, w_qual, w_new_cand, w_commit, w_illegal_beat, w_timeout;
  logic [7:0]  w_ascii;

  logic [7:0]  r_letter_ascii;
  logic [4:0]  r_letter_idx;
  logic        r_out_valid, r_overflow, r_illegal;
  logic [15:0] r_commit_count;

  assign w_legal    = {1'b0, idx_in} < NUM_N;
  assign w_qual     = valid_i & w_legal & (data_in >= SCORE_THRESH);
  assign w_new_cand = (r_state == IDLE) || (idx_in != r_cand);

`ifdef ASL_FILTER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] r_timer;

  // a valid_i in the timeout cycle wins, so the timer only fires when idle
  assign w_timeout = (r_state != IDLE) && !valid_i &&
                     (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || valid_i || (r_state == IDLE) || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_cand  <= w_cand_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_count_next = r_count;
    if (valid_i) begin
      if (!w_qual) begin
        // a low-confidence gap re-arms emission of the same letter
        w_state_next = IDLE;
        w_count_next = '0;
      end else if (w_new_cand) begin
        w_cand_next  = idx_in;
        w_count_next = 4'd1;
        w_state_next = (STABLE_N == 4'd1) ? LOCKED : COUNT;
      end else if (r_state == COUNT) begin
        w_count_next = r_count + 4'd1;
        if (r_count + 4'd1 == STABLE_N) begin
          w_state_next = LOCKED;
        end
      end
    end else if (w_timeout) begin
      w_state_next = IDLE;
      w_count_next = '0;
    end
  end

  always_comb begin
    w_illegal_beat = valid_i & ~w_legal;
    w_commit       = 1'b0;
    if (w_qual) begin
      if (w_new_cand) begin
        w_commit = (STABLE_N == 4'd1);
      end else if (r_state == COUNT) begin
        w_commit = (r_count + 4'd1 == STABLE_N);
      end
    end
  end

  asl_letter_lut u_lut (
    .i_idx   (idx_in),
    .o_ascii (w_ascii)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_letter_ascii <= '0;
      r_letter_idx   <= '0;
      r_out_valid    <= 1'b0;
      r_overflow     <= 1'b0;
      r_illegal      <= 1'b0;
      r_commit_count <= '0;
    end else begin
      if (w_illegal_beat) begin
        r_illegal <= 1'b1;
      end
      if (w_commit) begin
        // an unaccepted letter is never overwritten
        if (r_out_valid && !out_ready) begin
          r_overflow <= 1'b1;
        end else begin
          r_letter_ascii <= w_ascii;
          r_letter_idx   <= idx_in;
          r_out_valid    <= 1'b1;
          r_commit_count <= r_commit_count + 16'd1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign letter_ascii = r_letter_ascii;
  assign letter_idx   = r_letter_idx;
  assign out_valid    = r_out_valid;
  assign overflow_o   = r_overflow;
  assign illegal_o    = r_illegal;
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_asl_prediction_filter.sv
// Self-checking bench for asl_prediction_filter: per-feature tasks with a
// scoreboard of expected letters matched against observed output transfers.
module tb_asl_prediction_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = '0;
  logic [4:0]  idx_in = '0;
  logic        valid_i = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  letter_ascii;
  logic [4:0]  letter_idx;
  logic        out_valid;
  logic        overflow_o;
  logic        illegal_o;
  logic [15:0] commit_count;

  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  int          rd = 0;
  int          errors = 0;
  int          checks = 0;
  int          exp_cc = 0;

  asl_prediction_filter dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .idx_in       (idx_in),
    .valid_i      (valid_i),
    .letter_ascii (letter_ascii),
    .letter_idx   (letter_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow_o   (overflow_o),
    .illegal_o    (illegal_o),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  // every completed transfer is recorded as {idx, ascii}
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_q.push_back({letter_idx, letter_ascii});
      $display("transfer: idx=%0d ascii=%h", letter_idx, letter_ascii);
    end
  end

  function automatic logic [12:0] ent(input int i);
    string letters = "ABCDEFGHIKLMNOPQRSTUVWXY";
    logic [7:0] ch;
    ch = letters.getc(i);
    return {5'(i), ch};
  endfunction

  task automatic beat(input logic [4:0] i, input logic [7:0] s);
    @(posedge clk); #1;
    idx_in = i; data_in = s; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic beats(input logic [4:0] i, input logic [7:0] s, input int n);
    for (int k = 0; k < n; k++) beat(i, s);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (letter_ascii !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h want 00", letter_ascii); end
    checks++; if (letter_idx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", letter_idx); end
    checks++; if (commit_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", commit_count); end
    checks++; if (overflow_o !== 1'b0 || illegal_o !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b ill=%b want 0 0", overflow_o, illegal_o); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [12:0] e;
    beats(5'd5, 8'd100, 3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got out_valid=%b want 0", out_valid); end
    beat(5'd5, 8'd100);
    exp_q.push_back({5'd5, 8'h46}); exp_cc++;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got out_valid=%b want 1", out_valid); end
    beat(5'd5, 8'd100);
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL basic_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL basic_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL basic_count: got %0d want %0d", commit_count, exp_cc); end
  endtask

  task automatic test_switch();
    logic [12:0] e;
    beats(5'd9, 8'd200, 3);
    beats(5'd10, 8'd200, 4);
    exp_q.push_back({5'd10, 8'h4C}); exp_cc++;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL switch_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL switch_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL switch_count: got %0d want %0d", commit_count, exp_cc); end
  endtask

  task automatic test_threshold();
    logic [12:0] e;
    beats(5'd3, 8'd63, 4);
    beats(5'd3, 8'd64, 4);
    exp_q.push_back(ent(3)); exp_cc++;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL thresh_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL thresh_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_rearm();
    logic [12:0] e;
    beats(5'd0, 8'd100, 4);
    exp_q.push_back({5'd0, 8'h41}); exp_cc++;
    beat(5'd0, 8'd10);
    beats(5'd0, 8'd80, 4);
    exp_q.push_back({5'd0, 8'h41}); exp_cc++;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL rearm_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL rearm_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL rearm_count: got %0d want %0d", commit_count, exp_cc); end
  endtask

  task automatic test_overflow();
    logic [12:0] e;
    out_ready = 1'b0;
    beats(5'd1, 8'd150, 4);
    exp_cc++;
    beats(5'd2, 8'd150, 4);
    checks++; if ({letter_idx, letter_ascii} !== {5'd1, 8'h42}) begin errors++; $display("FAIL ovf_hold: got %0d/%h want 1/42", letter_idx, letter_ascii); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL ovf_count: got %0d want %0d", commit_count, exp_cc); end
    out_ready = 1'b1;
    exp_q.push_back({5'd1, 8'h42});
    repeat (3) @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got out_valid=%b want 0", out_valid); end
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL ovf_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL ovf_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_illegal();
    logic [12:0] e;
    beat(5'd30, 8'd255);
    checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", illegal_o); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_out: got out_valid=%b want 0", out_valid); end
    beats(5'd4, 8'd120, 3);
    beat(5'd24, 8'd255);
    beats(5'd4, 8'd120, 3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_restart: got out_valid=%b want 0", out_valid); end
    beat(5'd4, 8'd120);
    exp_q.push_back(ent(4)); exp_cc++;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL illegal_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL illegal_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    out_ready = 1'b0;
    beats(5'd8, 8'd90, 4);
    beats(5'd6, 8'd90, 3);
    pulse_reset();
    exp_cc = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    checks++; if (commit_count !== 16'd0 || illegal_o !== 1'b0 || overflow_o !== 1'b0) begin errors++; $display("FAIL rmid_clear: got cnt=%0d ill=%b ovf=%b want 0 0 0", commit_count, illegal_o, overflow_o); end
    out_ready = 1'b1;
    beats(5'd6, 8'd90, 3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early: got out_valid=%b want 0", out_valid); end
    beat(5'd6, 8'd90);
    exp_q.push_back(ent(6)); exp_cc++;
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL rmid_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL rmid_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL rmid_count: got %0d want %0d", commit_count, exp_cc); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    out_ready = 1'b0;
    beats(5'd11, 8'd200, 4);
    exp_q.push_back(ent(11)); exp_cc++;
    beats(5'd12, 8'd200, 3);
    // committing beat lands in the same cycle as the pending handshake
    @(posedge clk); #1;
    out_ready = 1'b1; idx_in = 5'd12; data_in = 8'd200; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    exp_q.push_back(ent(12)); exp_cc++;
    checks++; if (out_valid !== 1'b1 || letter_idx !== 5'd12) begin errors++; $display("FAIL b2b_refill: got v=%b idx=%0d want 1 12", out_valid, letter_idx); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", overflow_o); end
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL b2b_outputs: got %0d want %0d", obs_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < obs_q.size()) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q[rd] !== e) begin errors++; $display("FAIL b2b_letter: got %h want %h", obs_q[rd], e); end
      rd++;
    end
    exp_q.delete();
    checks++; if (commit_count !== 16'(exp_cc)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", commit_count, exp_cc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_switch();
    test_threshold();
    test_rearm();
    test_overflow();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asl_prediction_filter.md
Name: asl_prediction_filter

Overview:
- Downstream consumer of the 24-class argmax stage; takes its per-frame winner (index, score, valid pulse).
- Debounces the winner: a letter is committed only after STABLE_COUNT consecutive qualifying frames agree.
- Maps the committed class to an ASCII letter and presents it on a ready/valid port for the UART/display path.
- Sits between the argmax stage and the character output path.

Parameters:
- NUM_CLASSES, 24, number of legal class indices; idx_in >= NUM_CLASSES is illegal.
- STABLE_COUNT, 4, consecutive agreeing qualifying frames required to commit; legal range 1..15.
- SCORE_THRESH, 8'd64, minimum unsigned score for a frame to qualify; larger score means stronger.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before a stale candidate/lock is dropped; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  winning score from the argmax stage.
- idx_in  in  5  winning class index.
- valid_i  in  1  single-cycle frame-valid pulse; no backpressure upstream.
- letter_ascii  out  8  committed ASCII letter.
- letter_idx  out  5  committed class index.
- out_valid  out  1  output holds a letter.
- out_ready  in  1  downstream accepts the letter.
- overflow_o  out  1  sticky: a commit was dropped because the output register was occupied.
- illegal_o  out  1  sticky: a valid_i beat arrived with idx_in >= NUM_CLASSES.
- commit_count  out  16  total committed letters; wraps at 16'hFFFF -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, candidate 0, count 0.
- States:
  - IDLE: no candidate.
  - COUNT: candidate held, count 1..STABLE_COUNT-1.
  - LOCKED: letter committed; waiting for a class change or a gap.
- Qualifying beat: valid_i=1, idx_in < NUM_CLASSES, data_in >= SCORE_THRESH.
- Beat processing on each valid_i:
  - Illegal idx: set illegal_o. Treat as non-qualifying.
  - Non-qualifying beat, any state: go to IDLE, count 0. A low-confidence gap re-arms emission of the same letter.
  - Qualifying beat, idx_in != candidate, or state IDLE: candidate=idx_in, count=1, go to COUNT. If STABLE_COUNT=1, commit on this beat and go to LOCKED instead.
  - Qualifying beat, idx_in == candidate, state COUNT: count+1. On reaching STABLE_COUNT, commit and go to LOCKED.
  - Qualifying beat, idx_in == candidate, state LOCKED: no change; no re-emission.
  - valid_i=0: state holds.
- Commit:
  - Load letter_idx/letter_ascii and raise out_valid on the next cycle. Latency is 1 cycle from the committing valid_i beat.
  - commit_count increments in the same cycle as the load.
  - If out_valid=1 and out_ready=0 in the commit cycle: new letter dropped, old letter kept, overflow_o set, commit_count not incremented. The FSM still enters LOCKED.
  - Commit in the same cycle as a completing handshake (out_valid & out_ready): new letter loaded, out_valid stays 1.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - out_valid drops the next cycle unless refilled that cycle.
  - letter_ascii and letter_idx are stable while out_valid=1 and out_ready=0.
- ASCII map, idx 0..23: A B C D E F G H I K L M N O P Q R S T U V W X Y. J and Z are omitted because they are motion signs.
- Sticky flags clear only on reset.
- Reset mid-operation: any pending output is discarded, out_valid drops the next cycle, all counters clear.

Optional Feature:
- Macro ASL_FILTER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in COUNT and LOCKED, cleared on every valid_i.
  - On reaching TIMEOUT_CYCLES-1 with no valid_i, state goes to IDLE and count clears.
  - A valid_i in the same cycle as the timeout takes precedence; no timeout occurs.
- Undefined: no counter; state persists indefinitely without valid_i.

Decomposition:
- Package asl_filter_pkg:
  - state enum {IDLE, COUNT, LOCKED};
  - NUM_CLASSES_DEF = 24;
  - class-index and ASCII typedefs;
  - function idx_to_ascii, returning 8'h3F ('?') for illegal indices.
- Sub-module asl_letter_lut: a combinational wrapper of idx_to_ascii, instantiated once on the commit path.
- FSM, counters and output register stay in the top.

Test Plan:
- Four valid_i beats, idx=5, score=100, out_ready=1 -> out_valid one cycle after the 4th beat; letter_idx=5, letter_ascii=8'h46 ('F'); commit_count=1. A 5th identical beat produces no output.
- Beats idx=9 x3, then idx=10 x4, score=200 -> no commit for 9. Commit idx=10 with letter_ascii=8'h4C ('L').
- Commit idx=0 (A), then score=10 beat, then idx=0 x4 at score=80 -> two separate 'A' commits; commit_count=2.
- Hold out_ready=0, commit idx=1, then commit idx=2 -> letter stays 'B'; overflow_o=1; commit_count=1. Raise out_ready -> 'B' transfers, out_valid=0.
- Beat idx=30, score=255 -> illegal_o=1, state IDLE, no output.
- Assert reset for one cycle in COUNT with count=3 -> the next 3 matching beats do not commit; the 4th does.
